// File: rtl/serial_addsub_if.sv
// ============================================================================
//  Module      : serial_addsub_if
//  Description : Request/result bundle for the bit-serial adder/subtractor.
//                The master issues operands with a start pulse; the slave
//                returns busy, a done pulse and the registered result.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_addsub_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, sub, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, sub, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial adder/subtractor. One full-adder slice with a
//                registered carry processes the operands LSB first, one bit
//                per clock, and reports sum, carry-out and signed overflow
//                with a single-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   serial_addsub_if.slave     bus
);

   // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
   localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q,    state_d;
   logic [WIDTH-1:0] a_sh_q,     a_sh_d;
   logic [WIDTH-1:0] b_sh_q,     b_sh_d;
   logic             carry_q,    carry_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [WIDTH-1:0] sum_q,      sum_d;
   logic             cout_q,     cout_d;
   logic             ovf_q,      ovf_d;

   logic             bit_s;
   logic             bit_c;

   // Single full-adder slice on the current LSBs and the stored carry.
   always_comb begin
      bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      bit_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
   end

   // Next-state and datapath update: load on accept, shift during RUN.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               // Subtraction is A + ~B + 1; cin is ignored in that case.
               a_sh_d  = bus.a;
               b_sh_d  = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            carry_d = bit_c;
            sum_d   = (sum_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               // carry_q is the carry into the MSB, bit_c the carry out.
               cout_d  = bit_c;
               ovf_d   = carry_q ^ bit_c;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Scoreboard bench for serial_addsub at WIDTH=8 and WIDTH=1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   serial_addsub_if #(.WIDTH(8)) if8 ();
   serial_addsub_if #(.WIDTH(1)) if1 ();

   serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
   serial_addsub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         acc;
   } exp_t;

   exp_t       q8[$];
   exp_t       q1[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;
   int         busy8  = 0;
   logic [7:0] last8  = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input logic s, input logic c, input int acc);
      exp_t e;
      int mask, half, ua, ub, sa, sb, res;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      ua   = int'(a) & mask;
      ub   = int'(b) & mask;
      if (s) begin
         e.sum  = 8'((ua - ub) & mask);
         e.cout = (ua >= ub);
      end else begin
         res    = ua + ub + int'(c);
         e.sum  = 8'(res & mask);
         e.cout = (res > mask);
      end
      sa    = (ua >= half) ? ua - (1 << w) : ua;
      sb    = (ub >= half) ? ub - (1 << w) : ub;
      res   = s ? (sa - sb) : (sa + sb + int'(c));
      e.ovf = (res > half - 1) || (res < -half);
      e.acc = acc;
      return e;
   endfunction

   // Monitor: pop and compare whenever a DUT raises done.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst || !if8.busy) busy8 = 0;
      else                  busy8 = busy8 + 1;

      if (if8.done) begin
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("FAIL w8_unexpected_done: done=1 with no pending operation");
         end else begin
            e = q8.pop_front();
            if (if8.sum !== e.sum || if8.cout !== e.cout || if8.overflow !== e.ovf) begin
               errors++;
               $display("FAIL w8_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                        if8.sum, if8.cout, if8.overflow, e.sum, e.cout, e.ovf);
            end
            checks++;
            if (cyc - e.acc != 8) begin
               errors++;
               $display("FAIL w8_latency: got %0d edges, expected 8", cyc - e.acc);
            end
            checks++;
            if (busy8 != 9) begin
               errors++;
               $display("FAIL w8_busy_cycles: got %0d, expected 9", busy8);
            end
            last8 = e.sum;
         end
      end

      if (if1.done) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL w1_unexpected_done: done=1 with no pending operation");
         end else begin
            e = q1.pop_front();
            if (if1.sum !== e.sum[0] || if1.cout !== e.cout || if1.overflow !== e.ovf) begin
               errors++;
               $display("FAIL w1_result: got sum=%b cout=%b ovf=%b, expected sum=%b cout=%b ovf=%b",
                        if1.sum, if1.cout, if1.overflow, e.sum[0], e.cout, e.ovf);
            end
            checks++;
            if (cyc - e.acc != 1) begin
               errors++;
               $display("FAIL w1_latency: got %0d edges, expected 1", cyc - e.acc);
            end
         end
      end
   end

   // Issue one WIDTH=8 operation once the DUT is idle, then scramble inputs.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
      int guard;
      guard = 0;
      @(negedge clk);
      while (if8.busy) begin
         @(negedge clk);
         guard++;
         if (guard > 100) begin
            checks++;
            errors++;
            $display("FAIL w8_idle_timeout: busy=%b after %0d cycles, expected 0", if8.busy, guard);
            return;
         end
      end
      if8.start = 1'b1;
      if8.a     = a;
      if8.b     = b;
      if8.sub   = s;
      if8.cin   = c;
      q8.push_back(model(8, a, b, s, c, cyc + 1));
      @(negedge clk);
      if8.start = 1'b0;
      if8.a     = 8'($urandom);
      if8.b     = 8'($urandom);
      if8.sub   = 1'($urandom);
      if8.cin   = 1'($urandom);
   endtask

   task automatic op1(input logic a, input logic b, input logic s, input logic c);
      int guard;
      guard = 0;
      @(negedge clk);
      while (if1.busy) begin
         @(negedge clk);
         guard++;
         if (guard > 100) begin
            checks++;
            errors++;
            $display("FAIL w1_idle_timeout: busy=%b after %0d cycles, expected 0", if1.busy, guard);
            return;
         end
      end
      if1.start = 1'b1;
      if1.a     = a;
      if1.b     = b;
      if1.sub   = s;
      if1.cin   = c;
      q1.push_back(model(1, {7'd0, a}, {7'd0, b}, s, c, cyc + 1));
      @(negedge clk);
      if1.start = 1'b0;
      if1.a     = 1'($urandom);
      if1.b     = 1'($urandom);
   endtask

   task automatic wait_idle8();
      int guard;
      guard = 0;
      while (if8.busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
   endtask

   initial begin : stim
      int guard;
      if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.sub = 1'b0; if8.cin = 1'b0;
      if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.sub = 1'b0; if1.cin = 1'b0;

      // Reset values
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({if8.busy, if8.done, if8.sum, if8.cout, if8.overflow} !== 12'd0) begin
         errors++;
         $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                  if8.busy, if8.done, if8.sum, if8.cout, if8.overflow);
      end
      checks++;
      if ({if1.busy, if1.done, if1.sum, if1.cout, if1.overflow} !== 5'd0) begin
         errors++;
         $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b ovf=%b, expected all 0",
                  if1.busy, if1.done, if1.sum, if1.cout, if1.overflow);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed cases
      op8(8'd100, 8'd27, 1'b0, 1'b0);
      op8(8'h7F,  8'h01, 1'b0, 1'b0);
      op8(8'hFF,  8'h01, 1'b0, 1'b1);
      op8(8'd5,   8'd7,  1'b1, 1'b0);
      op8(8'h80,  8'h01, 1'b1, 1'b1);

      // Result held after done until the next accept
      wait_idle8();
      repeat (3) @(negedge clk);
      checks++;
      if (if8.sum !== last8) begin
         errors++;
         $display("FAIL w8_sum_hold: got %h, expected %h", if8.sum, last8);
      end

      // Start during RUN must be ignored
      op8(8'h3C, 8'h55, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h11; if8.sub = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      op8(8'hAA, 8'h11, 1'b1, 1'b0);

      // Reset in the middle of RUN
      op8(8'd10, 8'd20, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({if8.busy, if8.done, if8.sum, if8.cout, if8.overflow} !== 12'd0) begin
         errors++;
         $display("FAIL w8_midrun_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                  if8.busy, if8.done, if8.sum, if8.cout, if8.overflow);
      end
      q8.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      op8(8'd10, 8'd20, 1'b0, 1'b0);

      // WIDTH=1 directed and random
      op1(1'b1, 1'b1, 1'b0, 1'b0);
      op1(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++)
         op1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

      // WIDTH=8 random
      for (int i = 0; i < 40; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

      // Drain both scoreboards
      guard = 0;
      while ((q8.size() != 0 || q1.size() != 0) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      checks++;
      if (q8.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain: pending w8=%0d w1=%0d, expected 0 0", q8.size(), q1.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
